// File: rtl/ln_mcif_wr.sv
// LN write DMA to AXI write bridge: splits a command/data request stream into
// AW and W channels and tracks outstanding B responses for nonposted completion.
module ln_mcif_wr #(
  parameter  int DW      = 256,
  parameter  int LEN_W   = 4,
  parameter  int MAX_OST = 8,
  localparam int PDW     = 2 + LEN_W + 32 + DW,
  localparam int OW      = $clog2(MAX_OST) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_vld,
  output logic              wr_req_rdy,
  input  logic [PDW-1:0]    wr_req_pd,
  output logic              wr_rsp_complete,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [DW-1:0]     wdata,
  output logic [DW/8-1:0]   wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              wr_err,
  output logic [OW-1:0]     ost_cnt
);

  typedef enum logic {S_CMD, S_DATA} state_t;

  state_t           r_state, w_state_next;
  logic             r_aw_vld;
  logic [31:0]      r_awaddr;
  logic [LEN_W-1:0] r_awlen;
  logic [LEN_W-1:0] r_beat;
  logic             r_pending_np;
  logic             r_complete;
  logic             r_err;
  logic [OW-1:0]    r_ost;

  logic             w_is_cmd;
  logic [31:0]      w_cmd_addr;
  logic [LEN_W-1:0] w_cmd_len;
  logic             w_cmd_np;
  logic [31:0]      w_cmd_base;
  logic             w_cmd_acc;
  logic             w_beat_hs;
  logic             w_dec;
  logic [OW-1:0]    w_ost_next;
  logic             w_done;
  logic             w_unused_pd;

  assign w_is_cmd    = wr_req_pd[PDW-1];
  assign w_cmd_addr  = wr_req_pd[31:0];
  assign w_cmd_len   = wr_req_pd[32 +: LEN_W];
  assign w_cmd_np    = wr_req_pd[32 + LEN_W];
  assign w_cmd_base  = wr_req_pd[33 + LEN_W +: 32];
  // Payload bits between the data field and the flag carry nothing.
  assign w_unused_pd = ^wr_req_pd;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CMD;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    wr_req_rdy   = 1'b0;
    wvalid       = 1'b0;
    wlast        = 1'b0;
    w_cmd_acc    = 1'b0;
    w_beat_hs    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_CMD: begin
          wr_req_rdy = !r_aw_vld && (r_ost < OW'(MAX_OST));
          w_cmd_acc  = wr_req_vld && wr_req_rdy && w_is_cmd;
          if (w_cmd_acc) w_state_next = S_DATA;
        end
        S_DATA: begin
          wvalid     = wr_req_vld;
          wr_req_rdy = wready;
          wlast      = (r_beat == r_awlen);
          w_beat_hs  = wvalid && wready;
          if (w_beat_hs && wlast) w_state_next = S_CMD;
        end
        default: w_state_next = S_CMD;
      endcase
    end
  end

  // Responses that arrive with nothing outstanding (e.g. after a reset) are dropped.
  assign w_dec = bvalid && (r_ost != '0);

  always_comb begin
    w_ost_next = r_ost;
    case ({w_cmd_acc, w_dec})
      2'b10:   w_ost_next = r_ost + OW'(1);
      2'b01:   w_ost_next = r_ost - OW'(1);
      default: w_ost_next = r_ost;
    endcase
  end

  assign w_done = r_pending_np && (w_ost_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_vld     <= 1'b0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_beat       <= '0;
      r_pending_np <= 1'b0;
      r_complete   <= 1'b0;
      r_err        <= 1'b0;
      r_ost        <= '0;
    end else begin
      r_ost      <= w_ost_next;
      r_complete <= w_done;
      if (w_cmd_acc) begin
        r_awaddr <= w_cmd_base + w_cmd_addr;
        r_awlen  <= w_cmd_len;
        r_beat   <= '0;
        r_aw_vld <= 1'b1;
      end else if (r_aw_vld && awready) begin
        r_aw_vld <= 1'b0;
      end
      if (w_beat_hs && !wlast) r_beat <= r_beat + LEN_W'(1);
      if (w_cmd_acc && w_cmd_np) r_pending_np <= 1'b1;
      else if (w_done)           r_pending_np <= 1'b0;
      if (bvalid && (bresp != 2'b00)) r_err <= 1'b1;
    end
  end

  assign awvalid         = r_aw_vld;
  assign awaddr          = r_awaddr;
  assign awlen           = 8'(r_awlen);
  assign awsize          = 3'($clog2(DW/8));
  assign awburst         = 2'b01;
  assign wdata           = wr_req_pd[DW-1:0];
  assign wstrb           = '1;
  assign bready          = 1'b1;
  assign ost_cnt         = r_ost;
  assign wr_err          = r_err;
  assign wr_rsp_complete = r_complete;

endmodule

// File: tb/tb_ln_mcif_wr.sv
// Scoreboard bench for ln_mcif_wr: expected AW/W transfers are queued as stimulus
// is driven and compared by a monitor as the DUT handshakes them.
module tb_ln_mcif_wr;
  localparam int DW    = 256;
  localparam int LEN_W = 4;
  localparam int PDW   = 2 + LEN_W + 32 + DW;
  localparam int OW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_req_vld;
  logic             wr_req_rdy;
  logic [PDW-1:0]   wr_req_pd;
  logic             wr_rsp_complete;
  logic             awvalid, awready;
  logic [31:0]      awaddr;
  logic [7:0]       awlen;
  logic [2:0]       awsize;
  logic [1:0]       awburst;
  logic             wvalid, wready;
  logic [DW-1:0]    wdata;
  logic [DW/8-1:0]  wstrb;
  logic             wlast;
  logic             bvalid, bready;
  logic [1:0]       bresp;
  logic             wr_err;
  logic [OW-1:0]    ost_cnt;

  int checks = 0;
  int errors = 0;
  int w_hs_cnt = 0;
  int cmp_cnt = 0;
  logic bp = 1'b0;
  logic [39:0] exp_aw_q[$];
  logic [DW:0] exp_w_q[$];
  logic [39:0] ea;
  logic [DW:0] ew;

  ln_mcif_wr #(.DW(DW), .LEN_W(LEN_W), .MAX_OST(8)) dut (
    .clk(clk), .rst(rst),
    .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_req_pd(wr_req_pd),
    .wr_rsp_complete(wr_rsp_complete),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .wr_err(wr_err), .ost_cnt(ost_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Handshakes complete at the next rising edge; inputs are stable from here to it.
  always @(negedge clk) begin
    if (!rst && awvalid && awready) begin
      checks++;
      if (exp_aw_q.size() == 0) begin
        errors++;
        $display("FAIL aw_unexpected: got addr=%h len=%0d, required none", awaddr, awlen);
      end else begin
        ea = exp_aw_q.pop_front();
        if ({awaddr, awlen} !== ea) begin
          errors++;
          $display("FAIL aw_fields: got addr=%h len=%0d, required addr=%h len=%0d",
                   awaddr, awlen, ea[39:8], ea[7:0]);
        end else
          $display("AW  addr=%h len=%0d", awaddr, awlen);
      end
    end
    if (!rst && wvalid && wready) begin
      w_hs_cnt++;
      checks++;
      if (exp_w_q.size() == 0) begin
        errors++;
        $display("FAIL w_unexpected: got data=%h last=%b, required none", wdata, wlast);
      end else begin
        ew = exp_w_q.pop_front();
        if ({wlast, wdata} !== ew) begin
          errors++;
          $display("FAIL w_beat: got last=%b data=%h, required last=%b data=%h",
                   wlast, wdata, ew[DW], ew[DW-1:0]);
        end else
          $display("W   data=%h last=%b", wdata, wlast);
      end
    end
    if (wr_rsp_complete) cmp_cnt++;
  end

  function automatic logic [PDW-1:0] mk_cmd(input logic [31:0] base, input logic [31:0] addr,
                                            input logic [LEN_W-1:0] len, input logic np);
    logic [PDW-1:0] pd;
    pd = '0;
    pd[PDW-1] = 1'b1;
    pd[31:0] = addr;
    pd[32 +: LEN_W] = len;
    pd[32 + LEN_W] = np;
    pd[33 + LEN_W +: 32] = base;
    return pd;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic send_cmd(input logic [31:0] base, input logic [31:0] addr,
                          input logic [LEN_W-1:0] len, input logic np);
    int n;
    n = 0;
    wr_req_vld = 1'b1;
    wr_req_pd  = mk_cmd(base, addr, len, np);
    exp_aw_q.push_back({base + addr, 8'(len)});
    @(negedge clk);
    while (!wr_req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: got wr_req_rdy=0 for 50 cycles, required 1");
    end
    @(posedge clk); #1;
    wr_req_vld = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int n;
    n = 0;
    wr_req_vld = 1'b1;
    wr_req_pd  = {1'b0, {(PDW-1-DW){1'b0}}, d};
    exp_w_q.push_back({last, d});
    @(negedge clk);
    while (!(wr_req_rdy && wvalid) && n < 50) begin
      @(posedge clk); #1;
      if (bp) wready = ~wready;
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got no W handshake in 50 cycles, required one");
    end
    @(posedge clk); #1;
    wr_req_vld = 1'b0;
    if (bp) wready = ~wready;
  endtask

  task automatic b_pulse(input logic [1:0] resp);
    bvalid = 1'b1;
    bresp  = resp;
    @(posedge clk); #1;
    bvalid = 1'b0;
    bresp  = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, wr_req_rdy, wr_rsp_complete, wr_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got aw/w/rdy/cmp/err=%b, required 00000",
               {awvalid, wvalid, wr_req_rdy, wr_rsp_complete, wr_err});
    end
    checks++;
    if ({ost_cnt, awaddr, awlen} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got ost=%0d addr=%h len=%0d, required 0/0/0", ost_cnt, awaddr, awlen);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: got wr_req_rdy=%b, required 1", wr_req_rdy);
    end
    $display("test_reset done");
    @(posedge clk); #1;
  endtask

  task automatic test_single_burst();
    int c0;
    awready = 1'b0;
    send_cmd(32'h1000, 32'h40, 4'd3, 1'b1);
    @(negedge clk);
    checks++;
    if ({awvalid, awaddr, awlen, ost_cnt} !== {1'b1, 32'h1040, 8'd3, 4'd1}) begin
      errors++;
      $display("FAIL single_aw: got v=%b addr=%h len=%0d ost=%0d, required 1/00001040/3/1",
               awvalid, awaddr, awlen, ost_cnt);
    end
    checks++;
    if ({awsize, awburst, wstrb} !== {3'd5, 2'b01, {(DW/8){1'b1}}}) begin
      errors++;
      $display("FAIL single_const: got size=%0d burst=%b strb=%h, required 5/01/all ones",
               awsize, awburst, wstrb);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_beat(rnd_data(), i == 3);
    @(negedge clk);
    checks++;
    if (awvalid !== 1'b1 || awaddr !== 32'h1040) begin
      errors++;
      $display("FAIL single_aw_hold: got v=%b addr=%h, required 1/00001040", awvalid, awaddr);
    end
    @(posedge clk); #1;
    awready = 1'b1;
    c0 = cmp_cnt;
    repeat (5) @(posedge clk);
    #1;
    b_pulse(2'b00);
    @(negedge clk);
    checks++;
    if (wr_rsp_complete !== 1'b1 || ost_cnt !== 4'd0 || cmp_cnt != c0) begin
      errors++;
      $display("FAIL single_complete: got cmp=%b ost=%0d early=%0d, required 1/0/0",
               wr_rsp_complete, ost_cnt, cmp_cnt - c0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (wr_rsp_complete !== 1'b0 || cmp_cnt != c0 + 1) begin
      errors++;
      $display("FAIL single_pulse_width: got cmp=%b pulses=%0d, required 0/1",
               wr_rsp_complete, cmp_cnt - c0);
    end
    $display("test_single_burst done");
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int h0;
    send_cmd(32'h0, 32'h200, 4'd7, 1'b0);
    h0 = w_hs_cnt;
    bp = 1'b1;
    wready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(rnd_data(), i == 7);
    bp = 1'b0;
    wready = 1'b1;
    @(negedge clk);
    checks++;
    if (w_hs_cnt - h0 != 8) begin
      errors++;
      $display("FAIL bp_beats: got %0d beats, required 8", w_hs_cnt - h0);
    end
    @(posedge clk); #1;
    b_pulse(2'b00);
    $display("test_backpressure done");
  endtask

  task automatic test_ost_limit();
    for (int i = 0; i < 8; i++) begin
      send_cmd(32'h0, 32'(i * 64), 4'd0, 1'b0);
      send_beat(rnd_data(), 1'b1);
    end
    wr_req_vld = 1'b1;
    wr_req_pd  = mk_cmd(32'h0, 32'h900, 4'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (wr_req_rdy !== 1'b0 || ost_cnt !== 4'd8) begin
      errors++;
      $display("FAIL ost_full: got rdy=%b ost=%0d, required 0/8", wr_req_rdy, ost_cnt);
    end
    @(posedge clk); #1;
    bvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL ost_full_b: got rdy=%b during B, required 0", wr_req_rdy);
    end
    exp_aw_q.push_back({32'h900, 8'd0});
    @(posedge clk); #1;
    bvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_req_rdy !== 1'b1 || ost_cnt !== 4'd7) begin
      errors++;
      $display("FAIL ost_release: got rdy=%b ost=%0d, required 1/7", wr_req_rdy, ost_cnt);
    end
    @(posedge clk); #1;
    wr_req_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (ost_cnt !== 4'd8) begin
      errors++;
      $display("FAIL ost_9th: got ost=%0d, required 8", ost_cnt);
    end
    @(posedge clk); #1;
    send_beat(rnd_data(), 1'b1);
    repeat (8) b_pulse(2'b00);
    @(negedge clk);
    checks++;
    if (ost_cnt !== 4'd0) begin
      errors++;
      $display("FAIL ost_drain: got ost=%0d, required 0", ost_cnt);
    end
    $display("test_ost_limit done");
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    int c0;
    for (int i = 0; i < 3; i++) begin
      send_cmd(32'h0, 32'(32'h100 + i * 16), 4'd0, 1'b0);
      send_beat(rnd_data(), 1'b1);
    end
    wr_req_vld = 1'b1;
    wr_req_pd  = mk_cmd(32'h0, 32'h300, 4'd0, 1'b0);
    exp_aw_q.push_back({32'h300, 8'd0});
    bvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_req_rdy !== 1'b1 || ost_cnt !== 4'd3) begin
      errors++;
      $display("FAIL sim_pre: got rdy=%b ost=%0d, required 1/3", wr_req_rdy, ost_cnt);
    end
    @(posedge clk); #1;
    wr_req_vld = 1'b0;
    bvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (ost_cnt !== 4'd3) begin
      errors++;
      $display("FAIL sim_ost: got ost=%0d, required 3", ost_cnt);
    end
    @(posedge clk); #1;
    send_beat(rnd_data(), 1'b1);
    send_cmd(32'h0, 32'h400, 4'd0, 1'b1);
    send_beat(rnd_data(), 1'b1);
    c0 = cmp_cnt;
    for (int k = 0; k < 4; k++) begin
      b_pulse(2'b00);
      @(negedge clk);
      checks++;
      if (wr_rsp_complete !== (k == 3)) begin
        errors++;
        $display("FAIL sim_np_b%0d: got cmp=%b, required %b", k, wr_rsp_complete, k == 3);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (cmp_cnt != c0 + 1) begin
      errors++;
      $display("FAIL sim_np_count: got %0d pulses, required 1", cmp_cnt - c0);
    end
    $display("test_simultaneous done");
    @(posedge clk); #1;
  endtask

  task automatic test_error_reset();
    send_cmd(32'h0, 32'h500, 4'd0, 1'b0);
    send_beat(rnd_data(), 1'b1);
    b_pulse(2'b10);
    @(negedge clk);
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got wr_err=%b, required 1", wr_err);
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got wr_err=%b, required 1", wr_err);
    end
    @(posedge clk); #1;
    awready = 1'b0;
    send_cmd(32'h0, 32'h600, 4'd3, 1'b1);
    send_beat(rnd_data(), 1'b0);
    rst = 1'b1;
    exp_aw_q.delete();
    exp_w_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    awready = 1'b1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, wr_rsp_complete, wr_err, ost_cnt, awaddr, awlen} !== '0) begin
      errors++;
      $display("FAIL rst_mid: got aw=%b w=%b cmp=%b err=%b ost=%0d addr=%h len=%0d, required all 0",
               awvalid, wvalid, wr_rsp_complete, wr_err, ost_cnt, awaddr, awlen);
    end
    @(posedge clk); #1;
    b_pulse(2'b00);
    @(negedge clk);
    checks++;
    if (ost_cnt !== 4'd0 || wr_rsp_complete !== 1'b0) begin
      errors++;
      $display("FAIL rst_stray_b: got ost=%0d cmp=%b, required 0/0", ost_cnt, wr_rsp_complete);
    end
    $display("test_error_reset done");
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    send_cmd(32'hFFFF_FFF0, 32'h20, 4'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (awaddr !== 32'h0000_0010) begin
      errors++;
      $display("FAIL wrap_addr: got %h, required 00000010", awaddr);
    end
    @(posedge clk); #1;
    send_beat(rnd_data(), 1'b1);
    b_pulse(2'b00);
    $display("test_wrap done");
  endtask

  initial begin
    rst = 1'b1;
    wr_req_vld = 1'b0;
    wr_req_pd = '0;
    awready = 1'b1;
    wready = 1'b1;
    bvalid = 1'b0;
    bresp = 2'b00;
    test_reset();
    test_single_burst();
    test_backpressure();
    test_ost_limit();
    test_simultaneous();
    test_wrap();
    test_error_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_aw_q.size() != 0 || exp_w_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got aw=%0d w=%0d pending, required 0/0",
               exp_aw_q.size(), exp_w_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ln_mcif_wr.md
LN_MCIF_WR -- requirements
Module: ln_mcif_wr

Interface
REQ-001 SHALL have parameter DW, 256, data beat width (MAX_DAT_DW*Tout).
REQ-002 SHALL have parameter LEN_W, 4, burst length field width (log2AXI_BURST_LEN).
REQ-003 SHALL have parameter MAX_OST, 8, maximum outstanding AXI write bursts (power of 2, at most 16).
REQ-004 SHALL use one clock; reset is synchronous and active-high: clk input 1, rising-edge clock.
REQ-005 SHALL have rst input 1, synchronous active-high reset.
REQ-006 SHALL have wr_req_vld input 1, request valid from the LN write DMA.
REQ-007 SHALL have wr_req_rdy output 1, request accepted when vld&rdy.
REQ-008 SHALL have wr_req_pd input 2+LEN_W+32+DW, packed command or data payload.
REQ-009 SHALL have wr_rsp_complete output 1, one-cycle pulse when a nonposted burst and all earlier bursts are acknowledged.
REQ-010 SHALL have AXI AW ports awvalid output 1, awready input 1, awaddr output 32, awlen output 8, awsize output 3, awburst output 2.
REQ-011 SHALL have AXI W ports wvalid output 1, wready input 1, wdata output DW, wstrb output DW/8, wlast output 1.
REQ-012 SHALL have AXI B ports bvalid input 1, bready output 1, bresp input 2.
REQ-013 SHALL have wr_err output 1, sticky, set on any bresp != 0.
REQ-014 SHALL have ost_cnt output log2(MAX_OST)+1, current outstanding burst count.

Function
REQ-015 SHALL decode the payload as a command when its MSB is 1; command fields from LSB: addr[31:0], len[LEN_W-1:0], nonposted (1), base[31:0]; remaining bits ignored.
REQ-016 SHALL decode the payload as data when its MSB is 0; wdata = pd[DW-1:0].
REQ-017 SHALL implement FSM states CMD and DATA; reset state CMD.
REQ-018 In CMD, SHALL assert wr_req_rdy only when the AW register is empty and ost_cnt < MAX_OST.
REQ-019 On command acceptance, SHALL register awaddr = base+addr (32-bit, wrap-around modulo 2^32), awlen = zero-extended len, beat counter = 0, latch nonposted, and move to DATA.
REQ-020 SHALL hold awvalid high with stable fields from the cycle after acceptance until awready; awsize = log2(DW/8), awburst = 2'b01.
REQ-021 SHALL increment ost_cnt on each command acceptance and decrement it on each bvalid (bready is tied 1); simultaneous increment and decrement leave it unchanged.
REQ-022 In DATA, SHALL combinationally drive wvalid = wr_req_vld and wr_req_rdy = wready; wstrb = all ones.
REQ-023 SHALL assert wlast when beat counter == awlen; on the wlast beat handshake, SHALL return to CMD; otherwise SHALL increment the beat counter.
REQ-024 SHALL permit W beats before the matching AW handshake completes, with no W/AW ordering dependency.
REQ-025 SHALL ignore a command-flagged payload presented in DATA; this is a protocol violation with undefined data and no required recovery.
REQ-026 SHALL set pending_np when a nonposted command is accepted.
REQ-027 SHALL pulse wr_rsp_complete for exactly one cycle in the cycle after ost_cnt becomes 0 while pending_np = 1, and clear pending_np in the same cycle.
REQ-028 SHALL deassert wvalid and awvalid and hold wr_req_rdy at 0 outside their respective states.
REQ-029 SHALL set wr_err on bvalid with bresp != 0, held until reset.

Reset
REQ-030 While rst = 1 at a clock edge: state = CMD; awvalid, wvalid, wr_req_rdy, wr_rsp_complete, wr_err, pending_np = 0; ost_cnt = 0; beat counter = 0; awaddr and awlen = 0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no further AW, W, or complete activity; responses arriving after reset do not decrement below 0 (decrement saturates at 0).

Verification
REQ-032 Single burst: cmd base=0x1000, addr=0x40, len=3, nonposted=1; 4 data beats; B okay after 5 cycles -> awaddr=0x1040, awlen=3, wlast on 4th beat only, one complete pulse 1 cycle after B.
REQ-033 Backpressure: wready toggling 1/0 each cycle during len=7 burst -> exactly 8 beats transferred, data order preserved, no beat dropped or duplicated.
REQ-034 Outstanding limit: 9 posted len=0 bursts with B withheld -> 8 accepted, wr_req_rdy=0 at 9th command, ost_cnt=8; release one B -> 9th accepted next cycle.
REQ-035 Simultaneous events: command acceptance and bvalid in the same cycle at ost_cnt=3 -> ost_cnt stays 3; nonposted last burst with three earlier B pending -> complete only after the 4th B.
REQ-036 Error/reset: bresp=2'b10 -> wr_err=1 and stays set; rst pulse mid-burst -> all outputs return to REQ-030 values next cycle.
REQ-037 Address wrap: base=0xFFFF_FFF0, addr=0x20 -> awaddr=0x0000_0010.
